// File: rtl/mem_bus_arbiter_if.sv
// Shared memory bus between the arbiter (master) and the memory system (slave).
//   bus_req/bus_we/bus_sel/bus_addr/bus_wdata : request side, driven by the master
//   bus_ack/bus_rdata                         : single-cycle completion strobe and read data
interface mem_bus_arbiter_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the CPU instruction-fetch port and MEM-stage data port onto one
// shared memory bus. MEM has priority. Results that arrive while the owning
// pipeline stage is stalled are parked in a per-port buffer until the stall
// releases. A flush discards pending results but never aborts a bus cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   stall[5:0]    : pipeline stall vector (bit 1 = IF hold, bit 4 = MEM hold)
//   flush         : exception flush
//   if_*          : fetch request / instruction / stall request
//   mem_*         : data access request / load data / stall request
//   bus           : shared bus master port (all request outputs registered)
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stallreq,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stallreq,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, BUS_MEM, BUS_IF, HOLD_MEM, HOLD_IF} state_t;

  state_t      state;
  logic        flush_flag;   // a flush was seen during the current bus cycle
  logic [31:0] if_buf;
  logic [31:0] mem_buf;

  logic if_hold, mem_hold, own_hold;
  logic ack_if, ack_mem, discard;
  logic unused_stall;

  assign if_hold      = stall[1];
  assign mem_hold     = stall[4];
  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

  assign ack_if   = (state == BUS_IF)  && bus.bus_ack;
  assign ack_mem  = (state == BUS_MEM) && bus.bus_ack;
  // Result is dropped if a flush arrives in the ack cycle or was seen earlier.
  assign discard  = flush || flush_flag;
  assign own_hold = (state == BUS_MEM) ? mem_hold : if_hold;

  // Read data: bypass in the ack cycle, parked buffer while held, else 0.
  assign if_rdata  = (ack_if && !discard)                 ? bus.bus_rdata :
                     (state == HOLD_IF)                   ? if_buf        : '0;
  assign mem_rdata = (ack_mem && !discard && !bus.bus_we) ? bus.bus_rdata :
                     (state == HOLD_MEM)                  ? mem_buf       : '0;

  assign if_stallreq  = if_req  && !flush && !ack_if  && (state != HOLD_IF);
  assign mem_stallreq = mem_req && !flush && !ack_mem && (state != HOLD_MEM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      flush_flag    <= 1'b0;
      if_buf        <= '0;
      mem_buf       <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_sel   <= '0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          flush_flag <= 1'b0;
          if (!flush && mem_req) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= mem_we;
            bus.bus_sel   <= mem_sel;
            bus.bus_addr  <= mem_addr;
            bus.bus_wdata <= mem_wdata;
            state         <= BUS_MEM;
          end else if (!flush && if_req) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= 1'b0;
            bus.bus_sel   <= 4'b1111;
            bus.bus_addr  <= if_addr;
            bus.bus_wdata <= '0;
            state         <= BUS_IF;
          end
        end
        BUS_MEM, BUS_IF: begin
          if (bus.bus_ack) begin
            // Leaving the bus cycle always passes through a bus_req-low cycle
            // (IDLE or HOLD) before the next launch.
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_sel   <= '0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            flush_flag    <= 1'b0;
            if (discard || !own_hold) begin
              state <= IDLE;
            end else if (state == BUS_MEM) begin
              // A store leaves no load data behind.
              mem_buf <= bus.bus_we ? '0 : bus.bus_rdata;
              state   <= HOLD_MEM;
            end else begin
              if_buf <= bus.bus_rdata;
              state  <= HOLD_IF;
            end
          end else if (flush) begin
            flush_flag <= 1'b1;
          end
        end
        HOLD_MEM: if (!mem_hold || flush) state <= IDLE;
        HOLD_IF:  if (!if_hold  || flush) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by a
// long randomized run, all checked every cycle against a transaction-level
// reference model (who owns the bus, what was launched, what is parked).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata;
  logic        if_stallreq, mem_stallreq;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stallreq(if_stallreq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // staged stimulus, applied at the falling edge
  logic        s_rst, s_flush, s_if_req, s_mem_req, s_mem_we, s_ack_force;
  logic [5:0]  s_stall;
  logic [3:0]  s_mem_sel;
  logic [31:0] s_if_addr, s_mem_addr, s_mem_wdata, s_rdata;
  int          ack_wait, wcnt, run_len, last_len;

  // reference model: one outstanding transaction, optionally one parked result
  logic        m_busy, m_own_mem, m_flushed, m_holding;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata, m_hold_data;

  // observations from the latest cycle, for directed checks
  logic        o_ack, o_bus_req, o_if_stall, o_mem_stall, o_bus_we;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_if_rdata, o_mem_rdata, o_bus_addr;

  task automatic model_reset();
    m_busy = 0; m_own_mem = 0; m_flushed = 0; m_holding = 0;
    m_we = 0; m_sel = 0; m_addr = 0; m_wdata = 0; m_hold_data = 0;
  endtask

  task automatic check_outputs();
    logic ack_i, ack_m, disc;
    logic [31:0] e_if, e_mem;
    ack_i = m_busy && !m_own_mem && bus.bus_ack;
    ack_m = m_busy &&  m_own_mem && bus.bus_ack;
    disc  = flush || m_flushed;
    e_if  = (ack_i && !disc) ? bus.bus_rdata :
            (m_holding && !m_own_mem) ? m_hold_data : 32'h0;
    e_mem = (ack_m && !disc && !m_we) ? bus.bus_rdata :
            (m_holding && m_own_mem) ? m_hold_data : 32'h0;
    chk("bus_req", 32'(bus.bus_req), 32'(m_busy));
    if (m_busy) begin
      chk("bus_addr",  bus.bus_addr,        m_addr);
      chk("bus_we",    32'(bus.bus_we),     32'(m_we));
      chk("bus_sel",   32'(bus.bus_sel),    32'(m_sel));
      chk("bus_wdata", bus.bus_wdata,       m_wdata);
    end
    if (rst) begin
      chk("rst_addr",  bus.bus_addr,        32'h0);
      chk("rst_sel",   32'(bus.bus_sel),    32'h0);
      chk("rst_we",    32'(bus.bus_we),     32'h0);
      chk("rst_wdata", bus.bus_wdata,       32'h0);
    end
    chk("if_rdata",  if_rdata,  e_if);
    chk("mem_rdata", mem_rdata, e_mem);
    chk("if_stallreq",  32'(if_stallreq),
        32'(if_req && !flush && !ack_i && !(m_holding && !m_own_mem)));
    chk("mem_stallreq", 32'(mem_stallreq),
        32'(mem_req && !flush && !ack_m && !(m_holding && m_own_mem)));
  endtask

  // Advance the model across the coming rising edge using this cycle's inputs.
  task automatic model_update();
    if (m_busy) begin
      if (flush) m_flushed = 1;
      if (bus.bus_ack) begin
        m_busy = 0;
        if (!m_flushed && (m_own_mem ? stall[4] : stall[1])) begin
          m_holding   = 1;
          m_hold_data = (m_own_mem && m_we) ? 32'h0 : bus.bus_rdata;
        end
        m_flushed = 0;
      end
    end else if (m_holding) begin
      if (flush || !(m_own_mem ? stall[4] : stall[1])) m_holding = 0;
    end else if (!flush && mem_req) begin
      m_busy = 1; m_own_mem = 1;
      m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_wdata;
    end else if (!flush && if_req) begin
      m_busy = 1; m_own_mem = 0;
      m_we = 0; m_sel = 4'b1111; m_addr = if_addr; m_wdata = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst = s_rst; stall = s_stall; flush = s_flush;
    if_req = s_if_req; if_addr = s_if_addr;
    mem_req = s_mem_req; mem_we = s_mem_we; mem_sel = s_mem_sel;
    mem_addr = s_mem_addr; mem_wdata = s_mem_wdata;
    bus.bus_rdata = s_rdata;
    bus.bus_ack   = s_ack_force || (bus.bus_req && wcnt >= ack_wait);
    #1;
    if (rst) begin model_reset(); wcnt = 0; end
    check_outputs();
    o_ack = bus.bus_ack && bus.bus_req; o_bus_req = bus.bus_req;
    o_if_stall = if_stallreq; o_mem_stall = mem_stallreq;
    o_if_rdata = if_rdata; o_mem_rdata = mem_rdata;
    o_bus_addr = bus.bus_addr; o_bus_sel = bus.bus_sel; o_bus_we = bus.bus_we;
    if (bus.bus_req) run_len++; else run_len = 0;
    if (o_ack) last_len = run_len;
    wcnt = (bus.bus_req && !bus.bus_ack) ? wcnt + 1 : 0;
    if (!rst) model_update();
  endtask

  task automatic wait_ack(input string tag, output logic seen);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (o_ack) seen = 1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  logic seen;

  initial begin
    s_rst = 1; s_flush = 0; s_stall = 0; s_ack_force = 0;
    s_if_req = 0; s_if_addr = 0; s_mem_req = 0; s_mem_we = 0; s_mem_sel = 0;
    s_mem_addr = 0; s_mem_wdata = 0; s_rdata = 0;
    ack_wait = 0; wcnt = 0; run_len = 0; last_len = 0;
    rst = 1; stall = 0; flush = 0; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_sel = 0; mem_addr = 0; mem_wdata = 0; bus.bus_ack = 0; bus.bus_rdata = 0;
    model_reset();
    repeat (2) step();
    s_rst = 0;
    repeat (2) step();

    // IF read, two wait cycles
    s_if_req = 1; s_if_addr = 32'h0000_1000; ack_wait = 2; s_rdata = 32'h3C01_0001;
    wait_ack("t1_ack_seen", seen);
    chk("t1_req_len",  32'(last_len), 32'd3);
    chk("t1_if_rdata", o_if_rdata, 32'h3C01_0001);
    chk("t1_stallreq", 32'(o_if_stall), 32'd0);
    s_if_req = 0;
    step();
    chk("t1_req_drop", 32'(o_bus_req), 32'd0);

    // simultaneous MEM + IF: MEM first, IF after one idle cycle
    s_mem_req = 1; s_mem_we = 0; s_mem_sel = 4'b1111; s_mem_addr = 32'h0000_2000;
    s_if_req = 1; s_if_addr = 32'h0000_3000; ack_wait = 0; s_rdata = 32'h1111_2222;
    step();
    chk("t2_if_stall0", 32'(o_if_stall), 32'd1);
    step();
    chk("t2_mem_first", o_bus_addr, 32'h0000_2000);
    chk("t2_if_stall1", 32'(o_if_stall), 32'd1);
    s_mem_req = 0;
    step();
    chk("t2_gap",       32'(o_bus_req), 32'd0);
    chk("t2_if_stall2", 32'(o_if_stall), 32'd1);
    step();
    chk("t2_if_next",   o_bus_addr, 32'h0000_3000);
    chk("t2_if_ack",    32'(o_ack), 32'd1);
    s_if_req = 0;
    step();

    // IF ack while IF stage is held: result parked
    s_if_req = 1; s_if_addr = 32'h0000_4000; ack_wait = 0; s_rdata = 32'hDEAD_BEEF;
    step();
    s_stall = 6'b000010;
    step();
    chk("t3_ack_rdata", o_if_rdata, 32'hDEAD_BEEF);
    s_rdata = 32'h0BAD_F00D;
    repeat (3) begin
      step();
      chk("t3_hold_rdata", o_if_rdata, 32'hDEAD_BEEF);
    end
    s_stall = 0;
    step();
    chk("t3_last_hold", o_if_rdata, 32'hDEAD_BEEF);
    s_if_req = 0;
    step();
    chk("t3_released", o_if_rdata, 32'h0);

    // flush during a MEM load: bus cycle completes, data discarded
    s_mem_req = 1; s_mem_we = 0; s_mem_sel = 4'b1111; s_mem_addr = 32'h0000_5000;
    ack_wait = 3; s_stall = 6'b010000; s_rdata = 32'h55AA_55AA;
    step();
    step();
    s_flush = 1;
    step();
    chk("t4_req_held", 32'(o_bus_req), 32'd1);
    s_flush = 0; s_mem_req = 0;
    wait_ack("t4_ack_seen", seen);
    chk("t4_discard", o_mem_rdata, 32'h0);
    repeat (2) begin
      step();
      chk("t4_no_launch", 32'(o_bus_req), 32'd0);
      chk("t4_no_hold",   o_mem_rdata, 32'h0);
    end
    s_stall = 0;

    // reset in the middle of an IF bus cycle; a stray ack afterwards is ignored
    s_if_req = 1; s_if_addr = 32'h0000_6000; ack_wait = 3;
    step();
    step();
    s_rst = 1;
    step();
    chk("t5_async_rst", 32'(o_bus_req), 32'd0);
    s_rst = 0; s_if_req = 0; s_ack_force = 1; s_rdata = 32'h0000_0077;
    step();
    chk("t5_late_ack", o_if_rdata, 32'h0);
    s_ack_force = 0;
    step();
    chk("t5_idle", 32'(o_bus_req), 32'd0);

    // MEM store
    s_mem_req = 1; s_mem_we = 1; s_mem_sel = 4'b0011; s_mem_addr = 32'h8000_0004;
    s_mem_wdata = 32'h0000_1234; ack_wait = 2; s_rdata = 32'hFFFF_0000;
    step();
    chk("t6_stall_pre", 32'(o_mem_stall), 32'd1);
    wait_ack("t6_ack_seen", seen);
    chk("t6_we",       32'(o_bus_we), 32'd1);
    chk("t6_sel",      32'(o_bus_sel), 32'b0011);
    chk("t6_stall",    32'(o_mem_stall), 32'd0);
    chk("t6_rdata",    o_mem_rdata, 32'h0);
    s_mem_req = 0;
    step();

    // randomized traffic; a stalled request is held until served
    for (int c = 0; c < 3000; c++) begin
      if (!o_if_stall) begin
        s_if_req  = ($urandom_range(0, 2) == 0);
        s_if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!o_mem_stall) begin
        s_mem_req   = ($urandom_range(0, 2) == 0);
        s_mem_we    = $urandom_range(0, 1) == 1;
        s_mem_sel   = 4'($urandom);
        s_mem_addr  = $urandom;
        s_mem_wdata = $urandom;
      end
      s_stall  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      s_flush  = ($urandom_range(0, 15) == 0);
      s_rdata  = $urandom;
      ack_wait = $urandom_range(0, 3);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 stall  in  6  pipeline stall vector; bit 1 holds the IF stage, bit 4 holds the MEM stage.
REQ-005 flush  in  1  exception flush; discard all pending requests and results.
REQ-006 if_req, if_addr  in  1, 32  instruction-fetch request and word address.
REQ-007 if_rdata, if_stallreq  out  32, 1  fetched instruction; stall request to ctrl.
REQ-008 mem_req, mem_we, mem_sel, mem_addr, mem_wdata  in  1, 1, 4, 32, 32  data access from MEM stage.
REQ-009 mem_rdata, mem_stallreq  out  32, 1  load data; stall request to ctrl.
REQ-010 bus_req, bus_we, bus_sel, bus_addr, bus_wdata  out  1, 1, 4, 32, 32  shared memory bus master signals, all registered.
REQ-011 bus_ack, bus_rdata  in  1, 32  single-cycle completion strobe and read data.

Function
REQ-012 SHALL implement FSM states IDLE, BUS_MEM, BUS_IF, HOLD_MEM, HOLD_IF.
REQ-013 IDLE, flush=0, mem_req=1: latch mem_* onto bus_* with bus_req=1 next edge, go BUS_MEM. MEM has priority over IF.
REQ-014 IDLE, flush=0, mem_req=0, if_req=1: drive if_addr, bus_we=0, bus_sel=4'b1111, bus_req=1, go BUS_IF.
REQ-015 IDLE, flush=1: no launch, stay IDLE.
REQ-016 BUS_x: bus_req and all bus_* outputs SHALL stay stable until the bus_ack cycle; transactions are never aborted.
REQ-017 BUS_x and bus_ack=1: capture bus_rdata into the x result buffer and drop bus_req at the next edge. Then go to HOLD_x if stall hold bit set and flush=0, otherwise IDLE.
REQ-018 BUS_x, bus_ack=1 and flush=1 (same or earlier cycle while in BUS_x): result discarded, go IDLE. A flush recorded during BUS_x SHALL be remembered in a one-bit flag cleared on return to IDLE.
REQ-019 HOLD_x: result buffer drives x_rdata; go IDLE when hold bit clears or flush=1.
REQ-020 x_rdata SHALL equal bus_rdata combinationally in the bus_ack cycle, the buffer in HOLD_x, and 0 otherwise.
REQ-021 if_stallreq SHALL be 1 when if_req=1 and flush=0, unless (state=BUS_IF and bus_ack=1) or state=HOLD_IF. mem_stallreq SHALL follow the same rule for MEM.
REQ-022 bus_req SHALL be low for at least one cycle between consecutive transactions (latency: launch edge plus bus wait plus one).
REQ-023 A request pending while the other port owns the bus SHALL wait with stallreq=1; no request is lost or duplicated.
REQ-024 Write transactions capture nothing; mem_rdata=0 for writes.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, all bus_* outputs 0, both buffers 0, and the flush flag 0, including mid-transaction.
REQ-026 After rst deasserts, the first transaction SHALL launch no earlier than the first rising edge with a request.

Verification
REQ-027 IF read, ack after 2 wait cycles, stall=0: bus_addr=if_addr held 3 cycles; if_rdata=0x3C010001 in the ack cycle; if_stallreq low in that cycle; bus_req low next cycle.
REQ-028 mem_req and if_req asserted in the same cycle in IDLE: MEM served first. IF launches after one idle cycle. if_stallreq stays 1 throughout.
REQ-029 IF ack with stall[1]=1 for 3 more cycles: state HOLD_IF; if_rdata holds the captured word 0xDEADBEEF; returns to IDLE when stall[1]=0.
REQ-030 flush pulse during BUS_MEM before ack: bus_req held until ack; data discarded; mem_rdata=0; no HOLD state; next launch only on a new request.
REQ-031 rst pulse while BUS_IF: bus_req=0 immediately (asynchronously); late bus_ack ignored; state IDLE.
REQ-032 MEM store, sel=4'b0011, addr 0x80000004, wdata 0x1234: bus_we=1 and bus_sel=0011 stable until ack; mem_stallreq drops in the ack cycle.
